// File: rtl/register_bank_pkg.sv
// register_bank_pkg: shared widths and named register indices for the LEGv8 register bank
// Provides DATA_W/ADDR_W, the XZR index, and the link-register / stack-pointer indices.
package register_bank_pkg;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned NREG = 2 ** ADDR_W;
  localparam int unsigned XZR = 31;
  localparam int unsigned LR = 30;
  localparam int unsigned SP = 28;
  typedef enum logic [1:0] {
    SRC_ZERO,
    SRC_BYPASS,
    SRC_STORED
  } read_src_e;
  function automatic read_src_e read_src(input logic is_zero, input logic hit);
    return is_zero ? SRC_ZERO : hit ? SRC_BYPASS : SRC_STORED;
  endfunction
endpackage

// File: rtl/register_read_port.sv
// register_read_port: one read port's zero / write-forward / stored-value priority mux
// Ports: idx_i read index, stored_i committed entry at idx_i, wr_en_i/wr_idx_i/wr_data_i
// the in-flight write (already qualified against the zero register), data_o resolved value.
module register_read_port
  import register_bank_pkg::*;
#(
  parameter int unsigned P_DATA_W = DATA_W,
  parameter int unsigned P_ADDR_W = ADDR_W,
  parameter int unsigned ZERO_REG = XZR,
  parameter bit BYPASS = 1'b1
) (
  input  logic [P_ADDR_W-1:0] idx_i,
  input  logic [P_DATA_W-1:0] stored_i,
  input  logic                wr_en_i,
  input  logic [P_ADDR_W-1:0] wr_idx_i,
  input  logic [P_DATA_W-1:0] wr_data_i,
  output logic [P_DATA_W-1:0] data_o
);
  localparam logic [P_ADDR_W-1:0] ZERO_IDX = P_ADDR_W'(ZERO_REG);
  read_src_e src;
  always_comb begin
    src = read_src(idx_i == ZERO_IDX, BYPASS && wr_en_i && wr_idx_i == idx_i);
    data_o = src == SRC_ZERO ? '0 : src == SRC_BYPASS ? wr_data_i : stored_i;
  end
endmodule

// File: rtl/register_bank.sv
// register_bank: 32x64 LEGv8 register file, two forwarded read ports, one debug port, XZR reads 0
// Ports: clk, reset (sync, active-high, clears all); readReg1/2 -> readData1/2 (ALU A/B);
// regWrite/writeReg/writeData write-back; dbgReg -> dbgData (committed state only).
module register_bank
  import register_bank_pkg::*;
#(
  parameter int unsigned P_DATA_W = DATA_W,
  parameter int unsigned P_ADDR_W = ADDR_W,
  parameter int unsigned ZERO_REG = XZR,
  parameter bit BYPASS = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [P_ADDR_W-1:0] readReg1,
  input  logic [P_ADDR_W-1:0] readReg2,
  output logic [P_DATA_W-1:0] readData1,
  output logic [P_DATA_W-1:0] readData2,
  input  logic                regWrite,
  input  logic [P_ADDR_W-1:0] writeReg,
  input  logic [P_DATA_W-1:0] writeData,
  input  logic [P_ADDR_W-1:0] dbgReg,
  output logic [P_DATA_W-1:0] dbgData
);
  localparam int unsigned N = 2 ** P_ADDR_W;
  localparam logic [P_ADDR_W-1:0] ZERO_IDX = P_ADDR_W'(ZERO_REG);
  logic [P_DATA_W-1:0] regs_q [N];
  logic [P_DATA_W-1:0] regs_d [N];
  logic                wr_en;
  // Forwarding ignores reset on purpose; only the commit below is blocked by it.
  assign wr_en = regWrite && writeReg != ZERO_IDX;
  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[writeReg] = writeData;
    if (reset) regs_d = '{default: '0};
  end
  always_ff @(posedge clk) regs_q <= regs_d;
  register_read_port #(
    .P_DATA_W(P_DATA_W), .P_ADDR_W(P_ADDR_W), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
  ) u_rd1 (
    .idx_i(readReg1), .stored_i(regs_q[readReg1]), .wr_en_i(wr_en),
    .wr_idx_i(writeReg), .wr_data_i(writeData), .data_o(readData1)
  );
  register_read_port #(
    .P_DATA_W(P_DATA_W), .P_ADDR_W(P_ADDR_W), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
  ) u_rd2 (
    .idx_i(readReg2), .stored_i(regs_q[readReg2]), .wr_en_i(wr_en),
    .wr_idx_i(writeReg), .wr_data_i(writeData), .data_o(readData2)
  );
  register_read_port #(
    .P_DATA_W(P_DATA_W), .P_ADDR_W(P_ADDR_W), .ZERO_REG(ZERO_REG), .BYPASS(1'b0)
  ) u_dbg (
    .idx_i(dbgReg), .stored_i(regs_q[dbgReg]), .wr_en_i(wr_en),
    .wr_idx_i(writeReg), .wr_data_i(writeData), .data_o(dbgData)
  );
endmodule
